// File: rtl/int_seq.sv
// Interrupt sequencer: synchronises int_req, takes it at instruction boundaries,
// drives the save register and vector load, and tracks ie / in-service state.
module int_seq #(
  parameter int unsigned       PC_W        = 12,
  parameter logic [PC_W-1:0]   VECTOR      = PC_W'(12'h001),
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            int_req,
  input  logic            inst_done,
  input  logic            enai,
  input  logic            disi,
  input  logic            reti,
  input  logic [PC_W-1:0] pc_next,
  input  logic            c_i,
  input  logic            z_i,
  output logic            save_we,
  output logic [PC_W-1:0] save_pc,
  output logic            save_c,
  output logic            save_z,
  output logic            vec_load,
  output logic [PC_W-1:0] vec_pc,
  output logic            restore,
  output logic            int_ack,
  output logic            ie,
  output logic            in_isr,
  output logic            reti_err
);

  typedef enum logic [1:0] {ST_RUN, ST_SAVE, ST_VEC, ST_ISR} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ie_q, ie_d;
  logic                   reti_err_q, reti_err_d;
  logic [PC_W-1:0]        save_pc_q, save_pc_d;
  logic                   save_c_q, save_c_d;
  logic                   save_z_q, save_z_d;

  logic req_s;
  logic boundary;
  logic take;

  assign req_s    = sync_q[SYNC_STAGES-1];
  assign boundary = cen & inst_done;
  // The decision uses the registered ie, so enai cannot admit a request in its own boundary.
  assign take     = (state_q == ST_RUN) & boundary & ie_q & req_s;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q     <= '0;
      ie_q       <= 1'b0;
      reti_err_q <= 1'b0;
      save_pc_q  <= '0;
      save_c_q   <= 1'b0;
      save_z_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      ie_q       <= ie_d;
      reti_err_q <= reti_err_d;
      save_pc_q  <= save_pc_d;
      save_c_q   <= save_c_d;
      save_z_q   <= save_z_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (cen) begin
      unique case (state_q)
        ST_RUN:  if (take) state_d = ST_SAVE;
        ST_SAVE: state_d = ST_VEC;
        ST_VEC:  state_d = ST_ISR;
        ST_ISR:  if (inst_done && reti) state_d = ST_RUN;
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    sync_d     = sync_q;
    ie_d       = ie_q;
    reti_err_d = reti_err_q;
    save_pc_d  = save_pc_q;
    save_c_d   = save_c_q;
    save_z_d   = save_z_q;

    if (cen) begin
      sync_d = {sync_q[SYNC_STAGES-2:0], int_req};
    end

    if (boundary && (state_q == ST_RUN || state_q == ST_ISR)) begin
      if (disi) begin
        ie_d = 1'b0;
      end else if (enai) begin
        ie_d = 1'b1;
      end
    end

    if (cen && state_q == ST_SAVE) begin
      ie_d = 1'b0;
    end

    // Return from the ISR re-enables interrupts regardless of enai/disi.
    if (boundary && reti && state_q == ST_ISR) begin
      ie_d = 1'b1;
    end

    if (boundary && reti && state_q == ST_RUN) begin
      reti_err_d = 1'b1;
    end

    if (take) begin
      save_pc_d = pc_next;
      save_c_d  = c_i;
      save_z_d  = z_i;
    end
  end

  // Output decode
  always_comb begin
    save_we  = 1'b0;
    vec_load = 1'b0;
    int_ack  = 1'b0;
    in_isr   = 1'b0;
    restore  = 1'b0;
    unique case (state_q)
      ST_SAVE: save_we = 1'b1;
      ST_VEC: begin
        vec_load = 1'b1;
        int_ack  = 1'b1;
      end
      ST_ISR: begin
        in_isr  = 1'b1;
        restore = boundary & reti;
      end
      default: ;
    endcase
  end

  assign save_pc  = save_pc_q;
  assign save_c   = save_c_q;
  assign save_z   = save_z_q;
  assign vec_pc   = VECTOR;
  assign ie       = ie_q;
  assign reti_err = reti_err_q;

endmodule

// File: tb/tb_int_seq.sv
// Directed testbench for int_seq: entry, no-nesting, return, cen stalls,
// reti outside ISR, enai/disi priority and asynchronous reset mid-sequence.
`timescale 1ns/1ps
module tb_int_seq;

  localparam int unsigned PC_W = 12;

  logic            clk;
  logic            rst;
  logic            cen;
  logic            int_req;
  logic            inst_done;
  logic            enai;
  logic            disi;
  logic            reti;
  logic [PC_W-1:0] pc_next;
  logic            c_i;
  logic            z_i;
  logic            save_we;
  logic [PC_W-1:0] save_pc;
  logic            save_c;
  logic            save_z;
  logic            vec_load;
  logic [PC_W-1:0] vec_pc;
  logic            restore;
  logic            int_ack;
  logic            ie;
  logic            in_isr;
  logic            reti_err;

  int checks;
  int failures;

  int_seq #(.PC_W(12), .VECTOR(12'h001), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .cen(cen), .int_req(int_req), .inst_done(inst_done),
    .enai(enai), .disi(disi), .reti(reti), .pc_next(pc_next), .c_i(c_i), .z_i(z_i),
    .save_we(save_we), .save_pc(save_pc), .save_c(save_c), .save_z(save_z),
    .vec_load(vec_load), .vec_pc(vec_pc), .restore(restore), .int_ack(int_ack),
    .ie(ie), .in_isr(in_isr), .reti_err(reti_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; cen = 1'b1; int_req = 1'b0; inst_done = 1'b0;
    enai = 1'b0; disi = 1'b0; reti = 1'b0; pc_next = '0; c_i = 1'b0; z_i = 1'b0;
    #3;
    check("rst_save_we", 32'(save_we), 32'd0);
    check("rst_vec_load", 32'(vec_load), 32'd0);
    check("rst_int_ack", 32'(int_ack), 32'd0);
    check("rst_restore", 32'(restore), 32'd0);
    check("rst_ie", 32'(ie), 32'd0);
    check("rst_in_isr", 32'(in_isr), 32'd0);
    check("rst_reti_err", 32'(reti_err), 32'd0);
    check("rst_save_pc", 32'(save_pc), 32'd0);
    check("rst_vec_pc", 32'(vec_pc), 32'h001);
    tick();
    rst = 1'b1;
    tick();

    // Request pending with ie=0: never taken
    int_req = 1'b1; inst_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ie0_no_save_we", 32'(save_we), 32'd0);
    end
    check("ie0_ie", 32'(ie), 32'd0);
    check("ie0_in_isr", 32'(in_isr), 32'd0);

    // enai boundary does not admit; next boundary does
    enai = 1'b1; pc_next = 12'h0A5; c_i = 1'b1; z_i = 1'b0;
    tick();
    check("enai_no_take", 32'(save_we), 32'd0);
    check("enai_ie", 32'(ie), 32'd1);
    enai = 1'b0;
    tick();
    check("entry_save_we", 32'(save_we), 32'd1);
    check("entry_save_pc", 32'(save_pc), 32'h0A5);
    check("entry_save_c", 32'(save_c), 32'd1);
    check("entry_save_z", 32'(save_z), 32'd0);
    check("entry_vec_load_early", 32'(vec_load), 32'd0);
    inst_done = 1'b0; pc_next = 12'h777; c_i = 1'b0; z_i = 1'b1;
    tick();
    check("vec_vec_load", 32'(vec_load), 32'd1);
    check("vec_int_ack", 32'(int_ack), 32'd1);
    check("vec_vec_pc", 32'(vec_pc), 32'h001);
    check("vec_save_we", 32'(save_we), 32'd0);
    check("vec_save_pc_hold", 32'(save_pc), 32'h0A5);
    tick();
    check("isr_in_isr", 32'(in_isr), 32'd1);
    check("isr_ie", 32'(ie), 32'd0);
    check("isr_vec_load", 32'(vec_load), 32'd0);

    // In ISR: request pulse and enai do not nest
    int_req = 1'b0;
    tick();
    int_req = 1'b1; enai = 1'b1; inst_done = 1'b1;
    tick();
    check("isr_enai_ie", 32'(ie), 32'd1);
    enai = 1'b0;
    tick();
    tick();
    check("isr_no_nest_we", 32'(save_we), 32'd0);
    check("isr_still_in", 32'(in_isr), 32'd1);

    // reti: restore during the boundary, then RUN with ie=1
    reti = 1'b1;
    #1;
    check("reti_restore", 32'(restore), 32'd1);
    tick();
    reti = 1'b0;
    check("ret_restore_off", 32'(restore), 32'd0);
    check("ret_ie", 32'(ie), 32'd1);
    check("ret_in_isr", 32'(in_isr), 32'd0);
    check("ret_no_take", 32'(save_we), 32'd0);
    pc_next = 12'h123; c_i = 1'b0; z_i = 1'b1;
    tick();
    check("reentry_save_we", 32'(save_we), 32'd1);
    check("reentry_save_pc", 32'(save_pc), 32'h123);
    check("reentry_save_z", 32'(save_z), 32'd1);
    inst_done = 1'b0;

    // cen stall while in SAVE
    cen = 1'b0;
    tick();
    check("stall1_save_we", 32'(save_we), 32'd1);
    check("stall1_vec_load", 32'(vec_load), 32'd0);
    tick();
    check("stall2_save_we", 32'(save_we), 32'd1);
    cen = 1'b1;
    tick();
    check("unstall_save_we", 32'(save_we), 32'd0);
    check("unstall_vec_load", 32'(vec_load), 32'd1);
    tick();
    check("unstall_in_isr", 32'(in_isr), 32'd1);

    // Drop request, return to RUN
    int_req = 1'b0;
    tick();
    tick();
    tick();
    reti = 1'b1; inst_done = 1'b1;
    tick();
    reti = 1'b0;
    check("ret2_in_isr", 32'(in_isr), 32'd0);
    check("ret2_ie", 32'(ie), 32'd1);

    // reti in RUN: sticky error, no restore, ie unchanged
    reti = 1'b1;
    #1;
    check("run_reti_restore", 32'(restore), 32'd0);
    tick();
    reti = 1'b0;
    check("run_reti_err", 32'(reti_err), 32'd1);
    check("run_reti_ie", 32'(ie), 32'd1);
    check("run_reti_in_isr", 32'(in_isr), 32'd0);
    tick();
    check("reti_err_sticky", 32'(reti_err), 32'd1);
    enai = 1'b1; disi = 1'b1;
    tick();
    check("enai_disi_ie", 32'(ie), 32'd0);
    enai = 1'b0; disi = 1'b0; inst_done = 1'b0;

    // Enter again and reset while in VECTOR
    int_req = 1'b1;
    tick();
    tick();
    enai = 1'b1; inst_done = 1'b1; pc_next = 12'h3C3;
    tick();
    check("r_enai_no_take", 32'(save_we), 32'd0);
    enai = 1'b0;
    tick();
    check("r_save_we", 32'(save_we), 32'd1);
    inst_done = 1'b0;
    tick();
    check("r_vec_load", 32'(vec_load), 32'd1);
    check("r_save_pc", 32'(save_pc), 32'h3C3);
    #2;
    rst = 1'b0;
    #1;
    check("arst_vec_load", 32'(vec_load), 32'd0);
    check("arst_int_ack", 32'(int_ack), 32'd0);
    check("arst_save_we", 32'(save_we), 32'd0);
    check("arst_ie", 32'(ie), 32'd0);
    check("arst_in_isr", 32'(in_isr), 32'd0);
    check("arst_save_pc", 32'(save_pc), 32'd0);
    check("arst_reti_err", 32'(reti_err), 32'd0);
    tick();
    check("arst_hold_vec_load", 32'(vec_load), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
